multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  FSM control unit for the multi-cycle RV32I core; successor of the single-cycle decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared instruction/data memory with a ready handshake.
//  Covers full RV32I ALU/branch set, JALR, LUI, AUIPC. Raises sticky traps on illegal opcodes and memory timeout.
// PARAMETERS
//  USE_MEM_READY   1   1: memory states wait for mem_ready; 0: memory always completes in 1 cycle
//  TIMEOUT_CYCLES  0   max stalled cycles per memory access before bus_error; 0 disables timeout
// PORTS
//  clk            in   1  clock
//  rst            in   1  reset, asynchronous, active-high
//  opcode         in   7  instr[6:0] from instruction register
//  funct3         in   3  instr[14:12]
//  funct7         in   7  instr[31:25]
//  alu_zero       in   1  ALU result == 0 (combinational, this cycle)
//  mem_ready      in   1  memory access completes this cycle
//  pc_write       out  1  PC <= result bus
//  ir_write       out  1  IR and old_pc capture
//  adr_src        out  1  0: PC, 1: ALUOut as memory address
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe
//  reg_write      out  1  register file write
//  result_src     out  2  00 ALUOut, 01 mem data, 10 ALU result
//  alu_src_a      out  2  00 PC, 01 old_pc, 10 rs1, 11 zero
//  alu_src_b      out  2  00 rs2, 01 imm, 10 const 4
//  imm_src        out  3  000 I, 001 S, 010 B, 011 U, 100 J
//  alu_control    out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
//  pc_clr_lsb     out  1  force PC[0]=0 on pc_write (JALR)
//  illegal_instr  out  1  sticky trap: illegal encoding
//  bus_error      out  1  sticky trap: memory timeout
// BEHAVIOUR
//  - State register and flags reset asynchronously: state=FETCH, jalr_flag=0, wait_cnt=0, traps=0.
//  - While rst=1, strobes pc_write/ir_write/mem_read/mem_write/reg_write=0; selects take FETCH values.
//  - Outputs combinational from state; strobes also depend on mem_ready and alu_zero. Default: all 0, ADD.
//  - done = mem_ready | ~USE_MEM_READY. Memory states hold (no state change) while !done.
//  - FETCH: mem_read, adr_src=0, a=PC, b=4, result_src=10; ir_write=pc_write=done; done -> DECODE.
//  - DECODE: a=old_pc, b=imm, imm_src per opcode (ALUOut <= branch/JAL/AUIPC target). Next state:
//    LW/SW->MEMADR, R->EXEC_R, OP-IMM->EXEC_I, BRANCH->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI,
//    AUIPC->ALUWB, else -> TRAP with illegal_instr=1.
//  - Legal only: LW/SW funct3=010; branch funct3 not 010/011; R funct7=0000000, or 0100000 with funct3 000/101;
//    SLLI funct7=0000000; SRLI/SRAI funct7 0000000/0100000; JALR funct3=000.
//  - MEMADR: a=rs1, b=imm (I or S) -> MEMREAD (LW) or MEMWRITE (SW).
//  - MEMREAD: mem_read, adr_src=1; done -> MEMWB. MEMWB: result_src=01, reg_write -> FETCH.
//  - MEMWRITE: mem_write, adr_src=1; done -> FETCH.
//  - EXEC_R: a=rs1, b=rs2. EXEC_I: a=rs1, b=imm(I). Both -> ALUWB. ALUWB: result_src=00, reg_write -> FETCH.
//  - alu_control from funct3/funct7 as in the ALU map. OP-IMM 011 = SLTIU. SUB/SRA only on R with funct7[5].
//  - BRANCH: a=rs1, b=rs2, result_src=00; alu_control = SUB (funct3[2]=0), SLT (11x=0 i.e. 10x), SLTU (11x).
//    taken = funct3[0] ^ (funct3[2] ? ~alu_zero : alu_zero); pc_write=taken -> FETCH.
//  - JALR: a=rs1, b=imm(I), set jalr_flag -> JAL. JAL: a=old_pc, b=4, result_src=00, pc_write=1,
//    pc_clr_lsb=jalr_flag; clear jalr_flag -> ALUWB (rd <= old_pc+4).
//  - LUI: a=zero, b=imm(U) -> ALUWB.
//  - wait_cnt: +1 each cycle in FETCH/MEMREAD/MEMWRITE with !done, saturating; cleared on any state change.
//    TIMEOUT_CYCLES>0 and wait_cnt==TIMEOUT_CYCLES-1 with !done -> TRAP, bus_error=1; no strobe that cycle.
//    mem_ready in that same cycle wins (normal completion).
//  - TRAP: all strobes 0, stays until rst. Reset mid-instruction aborts it immediately, next is FETCH.
//  - CPI: ALU 4, LW 5, SW 4, branch 3, JAL 4, JALR 5, LUI 4, AUIPC 3 (zero wait states).
// STRUCTURE
//  - rv_ctrl_pkg: state enum, alu_op_e, imm_src_e, opcode localparams, src-select encodings.
//  - alu_decoder sub-module: opcode/funct3/funct7 -> alu_control + legal; FSM and counter in top.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3), ready=1 -> states F,D,EXEC_R,ALUWB; reg_write only in 4th cycle, alu_control=0000.
//  - LW with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_read=1 throughout, reg_write in MEMWB.
//  - BLT with alu_zero=0 -> alu_control=1000, pc_write=1; BGE same operands -> pc_write=0.
//  - JALR x1,0(x5) -> JALR, JAL with pc_write=1, pc_clr_lsb=1, then ALUWB reg_write=1.
//  - opcode 0x7F, and SUB funct7=0x20 with funct3=010 -> TRAP, illegal_instr=1 sticky, no strobes until rst.
//  - TIMEOUT_CYCLES=8, mem_ready stuck 0 in FETCH -> bus_error after 8 cycles; rst mid-wait -> FETCH, flags 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate format used while DECODE precomputes old_pc + imm.
  function automatic imm_src_e imm_for_opcode(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

  // Integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps opcode/funct3/funct7 to the ALU operation and flags illegal encodings.
module alu_decoder import rv_ctrl_pkg::*; (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_control,
  output logic       legal
);

  // Operation select and legality check per instruction class.
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    case (opcode)
      OP_R: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        alu_control = arith_op(funct3, funct7[5]);
      end
      OP_IMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        // funct7 is immediate data except on shifts, so SUB never applies here
        alu_control = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OP_BRANCH: begin
        legal = (funct3[2:1] != 2'b01);
        if (!funct3[2])     alu_control = ALU_SUB;
        else if (funct3[1]) alu_control = ALU_SLTU;
        else                alu_control = ALU_SLT;
      end
      OP_LOAD, OP_STORE:       legal = (funct3 == 3'b010);
      OP_JALR:                 legal = (funct3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                 legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// FSM control unit for the multi-cycle RV32I core with memory handshake and sticky traps.
module multicycle_controller import rv_ctrl_pkg::*; #(
  parameter bit          USE_MEM_READY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       pc_clr_lsb,
  output logic       illegal_instr,
  output logic       bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic             jalr_flag_q, jalr_flag_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  alu_op_e dec_op;
  logic    dec_legal;
  logic    done, mem_state, timeout, taken;

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (dec_op),
    .legal       (dec_legal)
  );

  assign done      = mem_ready | ~USE_MEM_READY;
  assign mem_state = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign timeout   = (TIMEOUT_CYCLES != 0) && mem_state && !done && (wait_cnt_q == CNT_LAST);
  assign taken     = funct3[0] ^ (funct3[2] ? ~alu_zero : alu_zero);

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

  // State and flag registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      jalr_flag_q <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      jalr_flag_q <= jalr_flag_d;
      illegal_q   <= illegal_d;
      bus_err_q   <= bus_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state, trap flags and stall counter.
  always_comb begin
    state_d     = state_q;
    jalr_flag_d = jalr_flag_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      S_FETCH:    if (done) state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXEC_R;
            OP_IMM:            state_d = S_EXEC_I;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_ALUWB;
            default: begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (done) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (done) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I,
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR: begin
        jalr_flag_d = 1'b1;
        state_d     = S_JAL;
      end
      S_JAL: begin
        jalr_flag_d = 1'b0;
        state_d     = S_ALUWB;
      end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    // timeout only fires while !done, so it never races a normal completion
    if (timeout) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end
    if (state_d != state_q)                  wait_cnt_d = '0;
    else if (mem_state && !done && (wait_cnt_q != '1)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
    else                                     wait_cnt_d = wait_cnt_q;
  end

  // Control outputs decoded from the current state.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    pc_clr_lsb  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = !timeout;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = done;
        pc_write   = done;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_for_opcode(opcode);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_read = !timeout;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = !timeout;
        adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_control = dec_op;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_op;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_control = dec_op;
        pc_write    = taken;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        pc_clr_lsb = jalr_flag_q;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle check of the full control word.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       pc_clr_lsb, illegal_instr, bus_error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.USE_MEM_READY(1'b1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .pc_clr_lsb(pc_clr_lsb), .illegal_instr(illegal_instr),
    .bus_error(bus_error)
  );

  // {pc_write,ir_write,adr_src,mem_read,mem_write,reg_write}, result_src, src_a, src_b,
  // imm_src, alu_control, {pc_clr_lsb,illegal_instr,bus_error}
  logic [21:0] obs;
  assign obs = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, pc_clr_lsb, illegal_instr, bus_error};

  function automatic logic [21:0] cw(input logic [5:0] s, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic [2:0] f);
    return {s, rs, a, b, imm, alu, f};
  endfunction

  function automatic logic [21:0] w_fetch();
    return cw(6'b110100, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 3'b000);
  endfunction
  function automatic logic [21:0] w_stall();
    return cw(6'b000100, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 3'b000);
  endfunction
  function automatic logic [21:0] w_rst();
    return cw(6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 3'b000);
  endfunction
  function automatic logic [21:0] w_dec(input logic [2:0] imm);
    return cw(6'b000000, 2'b00, 2'b01, 2'b01, imm, 4'b0000, 3'b000);
  endfunction
  function automatic logic [21:0] w_wb();
    return cw(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000);
  endfunction

  task automatic set_f(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    alu_zero = 1'b0;
    set_f(7'b0110011, 3'b000, 7'b0000000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (obs !== w_rst()) begin
        $display("FAIL reset c%0d: got %h want %h", c, obs, w_rst());
        miscompares++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [21:0] ev[$];
    opcode = 7'h33;
    {funct7, funct3, opcode} = {7'h00, 3'b000, 7'h33};
    begin
      logic [31:0] ins;
      ins = 32'h002081B3;
      opcode = ins[6:0];
      funct3 = ins[14:12];
      funct7 = ins[31:25];
    end
    mem_ready = 1'b1;
    ev = '{w_fetch(), w_dec(3'b000),
           cw(6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0000, 3'b000), w_wb()};
    foreach (ev[i]) begin
      #1;
      vectors++;
      if (obs !== ev[i]) begin
        $display("FAIL add c%0d: got %h want %h", i, obs, ev[i]);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    // {opcode, funct3, funct7, expected alu_control}
    logic [20:0] tbl[8];
    logic [21:0] ev[$];
    tbl = '{{7'b0110011, 3'b000, 7'b0100000, 4'b0001},   // SUB
            {7'b0110011, 3'b101, 7'b0100000, 4'b0111},   // SRA
            {7'b0110011, 3'b011, 7'b0000000, 4'b1001},   // SLTU
            {7'b0110011, 3'b111, 7'b0000000, 4'b0010},   // AND
            {7'b0010011, 3'b000, 7'b0100000, 4'b0000},   // ADDI, negative imm
            {7'b0010011, 3'b011, 7'b0000000, 4'b1001},   // SLTIU
            {7'b0010011, 3'b001, 7'b0000000, 4'b0101},   // SLLI
            {7'b0010011, 3'b100, 7'b1111111, 4'b0100}};  // XORI
    for (int t = 0; t < 8; t++) begin
      set_f(tbl[t][20:14], tbl[t][13:11], tbl[t][10:4]);
      ev = '{w_fetch(), w_dec(3'b000),
             cw(6'b000000, 2'b00, 2'b10, (tbl[t][20:14] == 7'b0010011) ? 2'b01 : 2'b00,
                3'b000, tbl[t][3:0], 3'b000),
             w_wb()};
      foreach (ev[i]) begin
        #1;
        vectors++;
        if (obs !== ev[i]) begin
          $display("FAIL alu_op t%0d c%0d: got %h want %h", t, i, obs, ev[i]);
          miscompares++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw_stall();
    logic [21:0] ev[$];
    logic        rv[$];
    set_f(7'b0000011, 3'b010, 7'b0000000);
    ev = '{w_fetch(), w_dec(3'b000),
           cw(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 3'b000),
           cw(6'b001100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000),
           cw(6'b001100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000),
           cw(6'b001100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000),
           cw(6'b001100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000),
           cw(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000)};
    rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    foreach (ev[i]) begin
      mem_ready = rv[i];
      #1;
      vectors++;
      if (obs !== ev[i]) begin
        $display("FAIL lw_stall c%0d: got %h want %h", i, obs, ev[i]);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [21:0] ev[$];
    logic        rv[$];
    set_f(7'b0100011, 3'b010, 7'b0000000);
    ev = '{w_fetch(), w_dec(3'b001),
           cw(6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 3'b000),
           cw(6'b001010, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000),
           cw(6'b001010, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b000)};
    rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (ev[i]) begin
      mem_ready = rv[i];
      #1;
      vectors++;
      if (obs !== ev[i]) begin
        $display("FAIL store c%0d: got %h want %h", i, obs, ev[i]);
        miscompares++;
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_branch();
    // {funct3, alu_zero, expected alu_control, expected taken}
    logic [8:0]  tbl[6];
    logic [21:0] ev[$];
    tbl = '{{3'b100, 1'b0, 4'b1000, 1'b1},   // BLT, rs1<rs2
            {3'b101, 1'b0, 4'b1000, 1'b0},   // BGE, same operands
            {3'b000, 1'b1, 4'b0001, 1'b1},   // BEQ equal
            {3'b001, 1'b1, 4'b0001, 1'b0},   // BNE equal
            {3'b110, 1'b0, 4'b1001, 1'b1},   // BLTU less
            {3'b111, 1'b1, 4'b1001, 1'b1}};  // BGEU not less
    for (int t = 0; t < 6; t++) begin
      set_f(7'b1100011, tbl[t][8:6], 7'b0000000);
      alu_zero = tbl[t][5];
      ev = '{w_fetch(), w_dec(3'b010),
             cw({tbl[t][0], 5'b00000}, 2'b00, 2'b10, 2'b00, 3'b000, tbl[t][4:1], 3'b000)};
      foreach (ev[i]) begin
        #1;
        vectors++;
        if (obs !== ev[i]) begin
          $display("FAIL branch t%0d c%0d: got %h want %h", t, i, obs, ev[i]);
          miscompares++;
        end
        @(negedge clk);
      end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [21:0] ev[$];
    logic [6:0]  oq[$];
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    // JALR x1,0(x5), then JAL, LUI, AUIPC back to back
    ev = '{w_fetch(), w_dec(3'b000),
           cw(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 3'b000),
           cw(6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 3'b100), w_wb(),
           w_fetch(), w_dec(3'b100),
           cw(6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 3'b000), w_wb(),
           w_fetch(), w_dec(3'b011),
           cw(6'b000000, 2'b00, 2'b11, 2'b01, 3'b011, 4'b0000, 3'b000), w_wb(),
           w_fetch(), w_dec(3'b011), w_wb()};
    oq = '{7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111,
           7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111,
           7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111,
           7'b0010111, 7'b0010111, 7'b0010111};
    foreach (ev[i]) begin
      opcode = oq[i];
      #1;
      vectors++;
      if (obs !== ev[i]) begin
        $display("FAIL jumps c%0d: got %h want %h", i, obs, ev[i]);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [21:0] ev[$];
    logic [16:0] ins[2];
    ins = '{{7'b1111111, 3'b000, 7'b0000000}, {7'b0110011, 3'b010, 7'b0100000}};
    for (int t = 0; t < 2; t++) begin
      set_f(ins[t][16:10], ins[t][9:7], ins[t][6:0]);
      alu_zero = 1'b1;
      mem_ready = 1'b1;
      ev = '{w_fetch(), w_dec(3'b000),
             cw(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b010),
             cw(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b010),
             cw(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b010)};
      foreach (ev[i]) begin
        #1;
        vectors++;
        if (obs !== ev[i]) begin
          $display("FAIL illegal t%0d c%0d: got %h want %h", t, i, obs, ev[i]);
          miscompares++;
        end
        @(negedge clk);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (obs !== w_rst()) begin
        $display("FAIL illegal_reset t%0d: got %h want %h", t, obs, w_rst());
        miscompares++;
      end
      @(negedge clk);
      rst = 1'b0;
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_timeout();
    logic [21:0] exp;
    set_f(7'b0110011, 3'b000, 7'b0000000);
    // eight stalled FETCH cycles, the last one expires without a strobe
    for (int c = 0; c < 10; c++) begin
      mem_ready = (c >= 8);
      if (c < 7)       exp = w_stall();
      else if (c == 7) exp = w_rst();
      else             exp = cw(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b001);
      #1;
      vectors++;
      if (obs !== exp) begin
        $display("FAIL timeout c%0d: got %h want %h", c, obs, exp);
        miscompares++;
      end
      @(negedge clk);
    end
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        // reset arriving in the middle of a stalled fetch
        for (int c = 0; c < 4; c++) begin
          mem_ready = 1'b0;
          #1;
          vectors++;
          if (obs !== w_stall()) begin
            $display("FAIL midwait_stall c%0d: got %h want %h", c, obs, w_stall());
            miscompares++;
          end
          @(negedge clk);
        end
      end
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (obs !== w_rst()) begin
        $display("FAIL timeout_reset r%0d: got %h want %h", r, obs, w_rst());
        miscompares++;
      end
      @(negedge clk);
      rst = 1'b0;
    end
    // seven stalls, then ready on the last permitted cycle completes normally
    for (int c = 0; c < 9; c++) begin
      mem_ready = (c >= 7);
      if (c < 7)       exp = w_stall();
      else if (c == 7) exp = w_fetch();
      else             exp = w_dec(3'b000);
      #1;
      vectors++;
      if (obs !== exp) begin
        $display("FAIL ready_wins c%0d: got %h want %h", c, obs, exp);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_lw_stall();
    test_store();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
